// File: rtl/life_pkg.sv
// Shared types and helpers for the 8x8 Game of Life sequencer.
package life_pkg;

  localparam int GRID_N = 8;
  localparam int GRID_W = GRID_N * GRID_N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Cell (r,c) lives at bit r*8+c, so the index is just the row and column concatenated.
  function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/life_evolve.sv
// Combinational B3/S23 next-generation logic for one 8x8 grid.
// LIFE_WRAP_EN defined: toroidal edges; undefined: cells beyond the border are dead.
module life_evolve
  import life_pkg::*;
(
  input  logic [GRID_W-1:0] cur,
  output logic [GRID_W-1:0] nxt
);

  logic [3:0] n;
  logic       alive;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    nxt   = '0;
    n     = '0;
    alive = 1'b0;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
`ifdef LIFE_WRAP_EN
              // Truncating to 3 bits gives the index modulo 8.
              alive = cur[cell_idx(3'(r + dr), 3'(c + dc))];
`else
              alive = (r + dr >= 0) && (r + dr < GRID_N) &&
                      (c + dc >= 0) && (c + dc < GRID_N) &&
                      cur[cell_idx(3'(r + dr), 3'(c + dc))];
`endif
              n = n + {3'b000, alive};
            end
          end
        end
        nxt[cell_idx(3'(r), 3'(c))] = (n == 4'd3) ||
                                      (cur[cell_idx(3'(r), 3'(c))] && (n == 4'd2));
      end
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Generation sequencer: load/run/pause/step control, rate divider and generation counter.
// Edge behaviour of the evolution follows the LIFE_WRAP_EN macro inside life_evolve.
module life_sequencer
  import life_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int GEN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       seed,
  input  logic              load,
  input  logic              run,
  input  logic              step,
  input  logic [DIV_W-1:0]  rate,
  output logic [63:0]       grid,
  output logic [GEN_W-1:0]  gen_count,
  output logic [1:0]        state,
  output logic              gen_tick,
  output logic              stable,
  output logic              empty
);

  state_t            state_q, state_d;
  logic [63:0]       grid_q, grid_d;
  logic [63:0]       next_grid;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic              apply;

  life_evolve u_evolve (
    .cur (grid_q),
    .nxt (next_grid)
  );

  // NOTE: state registers use non-blocking assignments; reset is sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grid_q  <= '0;
      gen_q   <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      gen_q   <= gen_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    gen_d   = gen_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    apply   = 1'b0;
    if (load) begin
      grid_d  = seed;
      gen_d   = '0;
      div_d   = '0;
      state_d = run ? RUN : PAUSE;
    end else begin
      case (state_q)
        PAUSE: begin
          if (run) begin
            state_d = RUN;
            div_d   = '0;
          end else if (step) begin
            apply = 1'b1;
          end
        end
        RUN: begin
          if (!run) begin
            state_d = PAUSE;
          end else if (div_q == rate) begin
            apply = 1'b1;
            div_d = '0;
          end else begin
            // Counts past a newly lowered rate and wraps naturally.
            div_d = div_q + DIV_W'(1);
          end
        end
        default: ;
      endcase

      if (apply) begin
        if (next_grid == grid_q) begin
          state_d = HALT;
        end else begin
          grid_d = next_grid;
          gen_d  = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
          tick_d = 1'b1;
        end
      end
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign state     = state_q;
  assign gen_tick  = tick_q;
  assign stable    = (state_q == HALT);
  assign empty     = (grid_q == '0);

endmodule
